// File: rtl/regfile_dump_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_dump_reader_pkg                                   |
// | Brief    : Shared types and constants for the register dump reader.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package regfile_dump_reader_pkg;

    localparam int REG_COUNT = 32;
    localparam int SEL_W     = 5;

    localparam logic [1:0] C_ENC_IDLE = 2'd0;
    localparam logic [1:0] C_ENC_LOAD = 2'd1;
    localparam logic [1:0] C_ENC_SEND = 2'd2;

    typedef enum logic [1:0] {
        IDLE = C_ENC_IDLE,
        LOAD = C_ENC_LOAD,
        SEND = C_ENC_SEND
    } state_t;

    // Register indices wrap from the top of the file back to index 0.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
        return (sel == SEL_W'(REG_COUNT - 1)) ? '0 : sel + SEL_W'(1);
    endfunction

endpackage : regfile_dump_reader_pkg
`default_nettype wire

// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_dump_reader_if                                    |
// | Brief    : Valid/ready word stream carrying a register value + index.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface regfile_dump_reader_if
    import regfile_dump_reader_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_index;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface : regfile_dump_reader_if
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_dump_reader                                       |
// | Brief    : Walks the register file debug port over an inclusive,     |
// |            wrapping index range and streams each captured value.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [SEL_W-1:0]  first_sel,
    input  wire logic [SEL_W-1:0]  last_sel,
    output logic      [SEL_W-1:0]  debug_sel,
    input  wire logic [WIDTH-1:0]  debug_data,
    regfile_dump_reader_if.master  out_if,
    output logic                   busy,
    output logic                   done
);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last_sel;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_index;
    logic             r_last;
    logic             r_busy;
    logic             r_done;

    logic             w_handshake;

    assign w_handshake = r_valid & out_if.out_ready;

    // r_sel doubles as the walking index: it is already on debug_sel during
    // LOAD, so the register file output is settled by the capture edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_last_sel <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_index    <= '0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sel      <= first_sel;
                        r_last_sel <= last_sel;
                        r_busy     <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_data  <= debug_data;
                    r_index <= r_sel;
                    r_last  <= (r_sel == r_last_sel);
                    r_valid <= 1'b1;
                    r_state <= SEND;
                end
                SEND: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_sel   <= next_sel(r_sel);
                            r_state <= LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign debug_sel        = r_sel;
    assign out_if.out_valid = r_valid;
    assign out_if.out_data  = r_data;
    assign out_if.out_index = r_index;
    assign out_if.out_last  = r_last;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule : regfile_dump_reader
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_regfile_dump_reader                                    |
// | Brief    : Scoreboard bench for the register dump reader.            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_regfile_dump_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  index;
        logic        last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  first_sel;
    logic [4:0]  last_sel;
    logic [4:0]  debug_sel;
    logic [31:0] debug_data;
    logic        busy;
    logic        done;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;

    logic [31:0] regs [32];

    exp_t exp_q [$];
    int   hs_q  [$];

    int n_tests;
    int n_fail;
    int cyc;
    int hs_cnt;
    int valid_rise_cyc;
    bit stall_mode;
    int stall_cnt;
    bit write_trick;
    bit prev_valid;
    bit prev_stall;
    logic [31:0] held_data;
    logic [4:0]  held_index;

    regfile_dump_reader_if #(.WIDTH(32)) sif ();

    assign sif.out_ready = out_ready;
    assign out_valid     = sif.out_valid;
    assign out_data      = sif.out_data;
    assign out_index     = sif.out_index;
    assign out_last      = sif.out_last;
    assign debug_data    = (debug_sel == 5'd0) ? 32'd0 : regs[debug_sel];

    regfile_dump_reader #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_sel  (first_sel),
        .last_sel   (last_sel),
        .debug_sel  (debug_sel),
        .debug_data (debug_data),
        .out_if     (sif),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ready driver and output monitor share one process so ready is settled before sampling.
    always @(negedge clk) begin
        exp_t e;
        if (stall_mode && out_valid) begin
            if (stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
                stall_cnt = 0;
            end
        end
        if (!reset) begin
            if (out_valid && !prev_valid) valid_rise_cyc = cyc;
            if (write_trick && out_valid && out_index == 5'd3) regs[3] = 32'hCAFE_0003;
            if (prev_stall) begin
                check_eq("stall_valid", out_valid, 1'b1);
                check_eq("stall_data",  out_data,  held_data);
                check_eq("stall_index", out_index, held_index);
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("word_data",  out_data,  e.data);
                    check_eq("word_index", out_index, e.index);
                    check_eq("word_last",  out_last,  e.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_index = out_index;
            prev_valid = out_valid;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns in the cycle after the sampling edge.
    task automatic start_dump(input logic [4:0] f, input logic [4:0] l, input bit push, output int acc);
        int   n;
        exp_t e;
        logic [4:0] idx;
        start     = 1'b1;
        first_sel = f;
        last_sel  = l;
        if (push) begin
            n = int'(5'(l - f)) + 1;
            for (int k = 0; k < n; k++) begin
                idx     = 5'(int'(f) + k);
                e.index = idx;
                e.data  = (idx == 5'd0) ? 32'd0 : regs[idx];
                e.last  = (k == n - 1);
                exp_q.push_back(e);
            end
        end
        tick();
        acc   = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d_cyc, output int busy_bad);
        int k;
        k        = 0;
        busy_bad = 0;
        while (!done && k < budget) begin
            if (!busy) busy_bad++;
            tick();
            k++;
        end
        check_eq("done_seen", done, 1'b1);
        d_cyc = cyc;
    endtask

    initial begin
        int acc, dcyc, bbad, h0, bad_gap, k;
        n_tests = 0; n_fail = 0; cyc = 0; hs_cnt = 0;
        stall_mode = 0; stall_cnt = 0; write_trick = 0;
        prev_valid = 0; prev_stall = 0; valid_rise_cyc = 0;
        start = 0; first_sel = 0; last_sel = 0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111_1111;
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_debug_sel", debug_sel, 5'd0);
        check_eq("rst_valid",     out_valid, 1'b0);
        check_eq("rst_data",      out_data,  32'd0);
        check_eq("rst_index",     out_index, 5'd0);
        check_eq("rst_last",      out_last,  1'b0);
        check_eq("rst_busy",      busy,      1'b0);
        check_eq("rst_done",      done,      1'b0);
        reset = 1'b0;
        tick();

        // Single word
        regs[5] = 32'hDEAD_BEEF;
        h0 = hs_cnt;
        start_dump(5'd5, 5'd5, 1, acc);
        wait_done(20, dcyc, bbad);
        check_eq("one_valid_lat", valid_rise_cyc - acc, 1);
        check_eq("one_done_lat",  dcyc - acc, 2);
        check_eq("one_hs_cnt",    hs_cnt - h0, 1);
        check_eq("one_busy",      bbad, 0);
        tick();

        // Full 32-register dump
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111_1111;
        h0 = hs_cnt;
        hs_q.delete();
        start_dump(5'd0, 5'd31, 1, acc);
        wait_done(200, dcyc, bbad);
        check_eq("full_hs_cnt", hs_cnt - h0, 32);
        bad_gap = 0;
        for (int i = 1; i < hs_q.size(); i++) if (hs_q[i] - hs_q[i-1] != 2) bad_gap++;
        check_eq("full_gaps",    bad_gap, 0);
        check_eq("full_last_hs", hs_q[hs_q.size()-1] - acc, 63);
        check_eq("full_done",    dcyc - acc, 64);
        check_eq("full_busy",    bbad, 0);
        tick();

        // Wrapping range
        h0 = hs_cnt;
        start_dump(5'd30, 5'd1, 1, acc);
        wait_done(40, dcyc, bbad);
        check_eq("wrap_hs_cnt", hs_cnt - h0, 4);
        tick();

        // Backpressure; reg 3 is rewritten while its word is held
        h0 = hs_cnt;
        stall_mode  = 1;
        write_trick = 1;
        start_dump(5'd3, 5'd4, 1, acc);
        wait_done(100, dcyc, bbad);
        stall_mode  = 0;
        write_trick = 0;
        out_ready   = 1'b1;
        check_eq("stall_hs_cnt", hs_cnt - h0, 2);
        check_eq("stall_busy",   bbad, 0);
        check_eq("done_busy_lo", busy, 1'b0);
        tick();

        // Start while busy is ignored; start with done is accepted
        h0 = hs_cnt;
        start_dump(5'd10, 5'd12, 1, acc);
        tick(); tick();
        start_dump(5'd0, 5'd31, 0, k);
        wait_done(60, dcyc, bbad);
        check_eq("busy_start_cnt", hs_cnt - h0, 3);
        start_dump(5'd20, 5'd21, 1, acc);
        check_eq("redo_load_valid", out_valid, 1'b0);
        check_eq("redo_load_busy",  busy,      1'b1);
        check_eq("redo_load_sel",   debug_sel, 5'd20);
        tick();
        check_eq("redo_send_valid", out_valid, 1'b1);
        wait_done(40, dcyc, bbad);
        check_eq("redo_q_empty", exp_q.size(), 0);
        tick();

        // Reset while a word is held
        out_ready = 1'b0;
        start_dump(5'd7, 5'd9, 1, acc);
        k = 0;
        while (!out_valid && k < 10) begin tick(); k++; end
        check_eq("pre_rst_index", out_index, 5'd7);
        #2 reset = 1'b1;
        #1;
        check_eq("ab_valid", out_valid, 1'b0);
        check_eq("ab_data",  out_data,  32'd0);
        check_eq("ab_index", out_index, 5'd0);
        check_eq("ab_last",  out_last,  1'b0);
        check_eq("ab_busy",  busy,      1'b0);
        check_eq("ab_sel",   debug_sel, 5'd0);
        exp_q.delete();
        tick(); tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        h0 = hs_cnt;
        repeat (10) tick();
        check_eq("post_rst_words", hs_cnt - h0, 0);
        check_eq("post_rst_done",  done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_dump_reader
`default_nettype wire

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the processor register file's debug read port. On a start command it walks the debug source select across a programmable register range, one register at a time. Each captured value goes out on a valid/ready stream tagged with its register index. It sits beside the register file in the debug path and feeds a host link such as UART or a debug bridge.

## Interface
Parameters:
- WIDTH, 32, data width; matches the register file width.

Ports (clock and reset first):
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_sel  input  5  first register index to dump; sampled with start.
- last_sel  input  5  last register index to dump, inclusive; sampled with start.
- debug_sel  output  5  drives the register file debug source select.
- debug_data  input  WIDTH  register file debug output, combinational from debug_sel.
- out_valid  output  1  stream word valid.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.
- out_data  output  WIDTH  captured register value.
- out_index  output  5  register index of out_data.
- out_last  output  1  high with the final word of the dump.
- busy  output  1  high from the cycle after start acceptance until the final handshake.
- done  output  1  one-cycle pulse in the cycle after the final handshake.

## Operation
- States: IDLE, LOAD, SEND.
- IDLE:
  - busy=0 and out_valid=0; debug_sel holds the last driven value.
  - start=1 latches first_sel and last_sel, sets idx=first_sel, and moves to LOAD.
- LOAD:
  - debug_sel=idx.
  - At the clock edge, capture debug_data into out_data and idx into out_index.
  - Set out_last=(idx==last), then move to SEND.
- SEND:
  - out_valid=1.
  - out_data, out_index and out_last are held stable until the handshake.
  - On handshake, if out_last=1: move to IDLE and pulse done.
  - On handshake, if out_last=0: set idx=idx+1 modulo 32 and move to LOAD.
- Range is inclusive and wraps: first=30 with last=1 dumps 30, 31, 0, 1. Word count = ((last−first) mod 32)+1; first==last dumps exactly one word.
- Index 0 is dumped like any other index; the register file returns zero for it.
- start while busy is ignored. start on the same cycle as the done pulse is accepted, because the state is already IDLE.
- Reset values: debug_sel=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0; state is IDLE.
- Reset mid-dump aborts immediately. No partial word is emitted after reset deasserts.

## Timing
- start accepted at edge N: LOAD in cycle N+1, first out_valid in cycle N+2.
- With out_ready held high, each word takes 2 cycles. A full 32-register dump takes 64 cycles from start acceptance to the last handshake, with done in the following cycle.
- debug_data is sampled only at the LOAD→SEND edge. Register file writes that occur during SEND are not reflected in the word being held.
- out_valid is never deasserted without a handshake, except by reset.
- No combinational path from out_ready to out_valid or out_data.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOAD, SEND);
  - REG_COUNT=32;
  - SEL_W=5.
- No sub-module needed. Keep the index counter, the capture register and the FSM in one module.

## Test plan
- Preload x5=0xDEADBEEF. Apply start with first=5, last=5 and out_ready=1 -> one word {0xDEADBEEF, idx 5, last=1}, out_valid in cycle N+2, done in cycle N+3.
- Preload xi=i*0x11111111. Apply start with first=0, last=31 and out_ready=1 -> 32 words with idx 0..31, data[0]=0, out_last only on idx 31, handshakes every 2 cycles.
- Apply start with first=30, last=1 -> words for idx 30, 31, 0, 1 in that order, out_last on idx 1.
- Dump first=3, last=4 with out_ready low for 5 cycles on each word -> out_data and out_index stable while stalled, exactly 2 handshakes, busy high throughout.
- Pulse start again while busy -> ignored and word count unchanged. Pulse start in the same cycle as done -> a new dump begins with LOAD in the next cycle.
- Assert reset while in SEND on idx 7 -> all outputs 0 immediately. No words appear after reset deasserts until a new start.
